// File: rtl/scan_sequencer.sv
// Host-side sequencer for the Tiny Tapeout scan chain: shift in, latch, capture, shift out.
// Define SCAN_CAPTURE_EN to include the capture and shift-out phases (read-back path).
module scan_sequencer #(
    parameter int NUM_DESIGNS = 2,
    parameter int DIV         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_index,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       scan_clk,
    output logic       scan_data_out,
    input  logic       scan_data_in,
    output logic       scan_select,
    output logic       scan_latch_en,
    output logic       busy
);

    localparam int L  = 8 * NUM_DESIGNS;
    localparam int BW = $clog2(L) + 1;
    localparam int TW = $clog2(DIV) + 1;

    localparam logic [BW-1:0] LAST_BIT  = BW'(L - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        LATCH,
        CAPTURE,
        SHIFT_OUT,
        RESP
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   tick_q;
    logic [BW-1:0]   bit_q;
    logic            phase_q;
    logic [7:0]      idx_q;
    logic [7:0]      data_q;
    logic            tick;
    logic            run;
    logic [BW-1:0]   bit_nxt;

`ifdef SCAN_CAPTURE_EN
    logic [7:0]      rx_q;
    logic            own_bit;
`else
    logic            unused_sdi;
    assign unused_sdi = scan_data_in;
`endif

    assign tick    = (tick_q == LAST_TICK);
    assign run     = (state_q != IDLE) && (state_q != RESP);
    assign bit_nxt = bit_q + BW'(1);

`ifdef SCAN_CAPTURE_EN
    assign own_bit = (int'(bit_q[BW-1:3]) == int'(idx_q));
`endif

    // Position p carries the target byte MSB first; design 0 sits nearest the tail.
    function automatic logic shift_bit(
        input logic [BW-1:0] p,
        input logic [7:0]    idx,
        input logic [7:0]    data
    );
        shift_bit = 1'b0;
        if (int'(p[BW-1:3]) == NUM_DESIGNS - 1 - int'(idx))
            shift_bit = data[~p[2:0]];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tick_q        <= '0;
            bit_q         <= '0;
            phase_q       <= 1'b0;
            idx_q         <= '0;
            data_q        <= '0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_data      <= 8'h00;
            rsp_err       <= 1'b0;
            scan_clk      <= 1'b0;
            scan_data_out <= 1'b0;
            scan_select   <= 1'b0;
            scan_latch_en <= 1'b0;
            busy          <= 1'b0;
`ifdef SCAN_CAPTURE_EN
            rx_q          <= '0;
`endif
        end else begin
            if (run)
                tick_q <= tick ? '0 : tick_q + TW'(1);

            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        idx_q     <= req_index;
                        data_q    <= req_data;
                        if (int'(req_index) >= NUM_DESIGNS) begin
                            state_q   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= 8'h00;
                        end else begin
                            state_q       <= SHIFT_IN;
                            tick_q        <= '0;
                            bit_q         <= '0;
                            phase_q       <= 1'b0;
                            rsp_err       <= 1'b0;
                            scan_data_out <= shift_bit('0, req_index, req_data);
                        end
                    end
                end

                SHIFT_IN: begin
                    if (tick) begin
                        phase_q  <= ~phase_q;
                        scan_clk <= ~phase_q;
                        if (phase_q) begin
                            if (bit_q == LAST_BIT) begin
                                state_q       <= LATCH;
                                bit_q         <= '0;
                                scan_data_out <= 1'b0;
                                scan_latch_en <= 1'b1;
                            end else begin
                                bit_q         <= bit_nxt;
                                scan_data_out <= shift_bit(bit_nxt, idx_q, data_q);
                            end
                        end
                    end
                end

                LATCH: begin
                    if (tick) begin
                        phase_q <= ~phase_q;
                        if (phase_q) begin
                            scan_latch_en <= 1'b0;
`ifdef SCAN_CAPTURE_EN
                            state_q     <= CAPTURE;
                            scan_select <= 1'b1;
`else
                            state_q   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= 8'h00;
                            rsp_err   <= 1'b0;
`endif
                        end
                    end
                end

`ifdef SCAN_CAPTURE_EN
                CAPTURE: begin
                    if (tick) begin
                        phase_q  <= ~phase_q;
                        scan_clk <= ~phase_q;
                        if (phase_q) begin
                            state_q     <= SHIFT_OUT;
                            scan_select <= 1'b0;
                            bit_q       <= '0;
                        end
                    end
                end

                // Tail is sampled on the edge that raises scan_clk, ahead of the shift.
                SHIFT_OUT: begin
                    if (tick) begin
                        phase_q  <= ~phase_q;
                        scan_clk <= ~phase_q;
                        if (!phase_q) begin
                            if (own_bit)
                                rx_q <= {rx_q[6:0], scan_data_in};
                        end else if (bit_q == LAST_BIT) begin
                            state_q   <= RESP;
                            bit_q     <= '0;
                            rsp_valid <= 1'b1;
                            rsp_data  <= rx_q;
                            rsp_err   <= 1'b0;
                        end else begin
                            bit_q <= bit_nxt;
                        end
                    end
                end
`endif

                RESP: begin
                    if (rsp_ready) begin
                        state_q   <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer with a behavioural scan-chain model.
// Expectations follow SCAN_CAPTURE_EN the same way the design does.
module tb_scan_sequencer;

    localparam int ND  = 2;
    localparam int DIV = 4;
    localparam int L   = 8 * ND;
`ifdef SCAN_CAPTURE_EN
    localparam bit CAP    = 1'b1;
    localparam int LAT    = (4 * L + 4) * DIV + 1;
    localparam int RST_AT = 200;
`else
    localparam bit CAP    = 1'b0;
    localparam int LAT    = (2 * L + 2) * DIV + 1;
    localparam int RST_AT = 100;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_index;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       scan_clk;
    logic       scan_data_out;
    logic       scan_data_in;
    logic       scan_select;
    logic       scan_latch_en;
    logic       busy;

    scan_sequencer #(.NUM_DESIGNS(ND), .DIV(DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_index    (req_index),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .scan_clk     (scan_clk),
        .scan_data_out(scan_data_out),
        .scan_data_in (scan_data_in),
        .scan_select  (scan_select),
        .scan_latch_en(scan_latch_en),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Chain model: design d occupies chain[8d+7:8d]; capture puts design 0 at the tail.
    logic [L-1:0] chain = '0;
    logic [7:0]   dout[ND];
    logic [7:0]   din[ND];
    bit           sin_log[$];

    assign scan_data_in = chain[L-1];

    always @(posedge scan_clk) begin
        if (scan_select) begin
            for (int d = 0; d < ND; d++)
                chain[L-1-8*d -: 8] <= dout[d];
        end else begin
            chain <= {chain[L-2:0], scan_data_out};
            sin_log.push_back(scan_data_out);
        end
    end

    always @(posedge scan_latch_en) begin
        for (int d = 0; d < ND; d++)
            din[d] = chain[8*d +: 8];
    end

    int   cyc = 0;
    int   acc_cyc = 0;
    int   rsp_done = 0;
    int   lat_cyc = 0;
    int   lat_pulses = 0;
    int   sel_cyc = 0;
    int   pin_cyc = 0;
    logic rsp_prev = 1'b0;
    logic lat_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (req_valid && req_ready)
            acc_cyc = cyc + 1;
        if (rsp_valid && !rsp_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 want no response");
            end else begin
                chk("latency", cyc - acc_cyc + 1, exp_q[0].lat);
            end
        end
        if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
            chk("rsp_data", {24'h0, rsp_data}, {24'h0, exp_q[0].data});
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_q[0].err});
            void'(exp_q.pop_front());
            rsp_done++;
        end
        rsp_prev = rsp_valid;
        if (scan_latch_en) lat_cyc++;
        if (scan_latch_en && !lat_prev) lat_pulses++;
        lat_prev = scan_latch_en;
        if (scan_select) sel_cyc++;
        if (scan_clk || scan_data_out || scan_select || scan_latch_en) pin_cyc++;
    end

    int s_sin, s_lat, s_lp, s_sel, s_pin;

    task automatic send(input logic [7:0] idx, input logic [7:0] data,
                        input logic [7:0] ed, input logic ee, input int el);
        exp_t e;
        int   n;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL req_ready_wait: got req_ready=0 want 1");
        end
        s_sin = sin_log.size();
        s_lat = lat_cyc;
        s_lp  = lat_pulses;
        s_sel = sel_cyc;
        s_pin = pin_cyc;
        e.data = ed;
        e.err  = ee;
        e.lat  = el;
        exp_q.push_back(e);
        req_index = idx;
        req_data  = data;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int start);
        int n;
        n = 0;
        while (rsp_done == start && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_done == start) begin
            failures++;
            $display("FAIL rsp_timeout: got no response want one within 2000 clocks");
        end
    endtask

    task automatic post_chk(input string t, input logic [L-1:0] exp_sin);
        logic [L-1:0] v;
        v = '0;
        for (int i = 0; i < L; i++)
            if (s_sin + i < sin_log.size())
                v = {v[L-2:0], 1'(sin_log[s_sin+i])};
        chk({t, "_sclk_rises"}, sin_log.size() - s_sin, CAP ? 2 * L : L);
        chk({t, "_shift_in"}, 32'(v), 32'(exp_sin));
        chk({t, "_latch_pulses"}, lat_pulses - s_lp, 1);
        chk({t, "_latch_clks"}, lat_cyc - s_lat, 2 * DIV);
        chk({t, "_select_clks"}, sel_cyc - s_sel, CAP ? 2 * DIV : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    int d0;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_index = 8'h00;
        req_data  = 8'h00;
        rsp_ready = 1'b1;
        for (int d = 0; d < ND; d++) dout[d] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 0);
        chk("rst_rsp_data", {24'h0, rsp_data}, 0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_scan_pins", {28'h0, scan_clk, scan_data_out, scan_select, scan_latch_en}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // index 1, A5 in, design 1 drives 3C
        dout[0] = 8'h11;
        dout[1] = 8'h3C;
        d0 = rsp_done;
        send(8'd1, 8'hA5, CAP ? 8'h3C : 8'h00, 1'b0, LAT);
        wait_rsp(d0);
        post_chk("t1", 16'hA500);
        chk("t1_din1", {24'h0, din[1]}, 32'h A5);
        chk("t1_din0", {24'h0, din[0]}, 32'h00);

        // index 0, FF in, design 0 drives 81
        dout[0] = 8'h81;
        dout[1] = 8'h7E;
        d0 = rsp_done;
        send(8'd0, 8'hFF, CAP ? 8'h81 : 8'h00, 1'b0, LAT);
        wait_rsp(d0);
        post_chk("t2", 16'h00FF);
        chk("t2_din0", {24'h0, din[0]}, 32'hFF);
        chk("t2_din1", {24'h0, din[1]}, 32'h00);

        // out of range index
        d0 = rsp_done;
        send(8'd2, 8'h33, 8'h00, 1'b1, 1);
        wait_rsp(d0);
        chk("t3_pin_activity", pin_cyc - s_pin, 0);
        chk("t3_sclk_rises", sin_log.size() - s_sin, 0);

        // response held for 20 clocks, stray request ignored
        dout[1] = 8'hC3;
        rsp_ready = 1'b0;
        d0 = rsp_done;
        send(8'd1, 8'h0F, CAP ? 8'hC3 : 8'h00, 1'b0, LAT);
        for (int n = 0; n < 2000 && !rsp_valid; n++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                req_index = 8'd0;
                req_data  = 8'h55;
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            chk("t4_hold_valid", {31'h0, rsp_valid}, 1);
            chk("t4_hold_data", {24'h0, rsp_data}, CAP ? 32'hC3 : 32'h00);
            chk("t4_hold_req_ready", {31'h0, req_ready}, 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_rsp(d0);
        repeat (20) @(negedge clk);
        chk("t4_no_stray_rsp", {31'h0, rsp_valid}, 0);
        chk("t4_idle_busy", {31'h0, busy}, 0);
        chk("t4_idle_req_ready", {31'h0, req_ready}, 1);

        // reset in the middle of an operation
        send(8'd1, 8'h96, 8'h00, 1'b0, LAT);
        for (int n = 0; n < 2000 && (cyc - acc_cyc + 1) < RST_AT; n++) @(negedge clk);
        chk("t5_reached_point", {31'h0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_pins", {28'h0, scan_clk, scan_data_out, scan_select, scan_latch_en}, 0);
        chk("t5_rst_busy", {31'h0, busy}, 0);
        chk("t5_rst_rsp_valid", {31'h0, rsp_valid}, 0);
        chk("t5_rst_req_ready", {31'h0, req_ready}, 1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_post_rsp_valid", {31'h0, rsp_valid}, 0);

        // full request after reset release
        dout[0] = 8'h24;
        dout[1] = 8'hE7;
        d0 = rsp_done;
        send(8'd1, 8'h5A, CAP ? 8'hE7 : 8'h00, 1'b0, LAT);
        wait_rsp(d0);
        post_chk("t6", 16'h5A00);
        chk("t6_din1", {24'h0, din[1]}, 32'h5A);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
